// File: rtl/demux_pkg.sv
// Shared definitions for the stream demultiplexer slice.
package demux_pkg;

    localparam int unsigned DROP_CNT_W = 8;

    // Select width for n channels; never below one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry valid/ready output register for a single demux channel.
module demux_chan_reg #(
    parameter int unsigned BITS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [BITS-1:0] load_data,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [BITS-1:0] out_data,
    output logic            free
);

    logic            valid_q, valid_d;
    logic [BITS-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            // A load in a draining cycle simply replaces the word and keeps valid high.
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign free      = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/demux_stream_1xn.sv
// Registered 1-to-N stream demux with broadcast, per-channel back-pressure and
// a saturating count of words dropped for out-of-range selects.
module demux_stream_1xn
    import demux_pkg::*;
#(
    parameter int unsigned BITS     = 4,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = sel_width(CHANNELS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [BITS-1:0]        in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_bcast,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [CHANNELS*BITS-1:0] out_data,
    output logic [CHANNELS-1:0]    out_valid,
    input  logic [CHANNELS-1:0]    out_ready,
    output logic [DROP_CNT_W-1:0]  drop_cnt
);

    logic [CHANNELS-1:0]   sel_hit;
    logic [CHANNELS-1:0]   free;
    logic [CHANNELS-1:0]   load;
    logic                  in_range;
    logic                  accept;
    logic                  drop;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        assign sel_hit[k] = (in_sel == SEL_W'(k));

        demux_chan_reg #(
            .BITS(BITS)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load[k]),
            .load_data(in_data),
            .out_ready(out_ready[k]),
            .out_valid(out_valid[k]),
            .out_data (out_data[k*BITS +: BITS]),
            .free     (free[k])
        );
    end

    // An empty one-hot means the select points past the last channel.
    assign in_range = |sel_hit;

    always_comb begin
        if (in_bcast) begin
            in_ready = &free;
        end else if (in_range) begin
            in_ready = |(sel_hit & free);
        end else begin
            in_ready = 1'b1;
        end
    end

    assign accept = in_valid & in_ready;
    assign load   = {CHANNELS{accept}} & ({CHANNELS{in_bcast}} | sel_hit);
    assign drop   = accept & ~in_bcast & ~in_range;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_stream_1xn.sv
// Directed bench for demux_stream_1xn with a per-channel ordered scoreboard.
module tb_demux_stream_1xn;

    typedef struct packed {
        logic [1:0] ch;
        logic [3:0] data;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [3:0]  data4;
    logic [1:0]  sel4;
    logic        bcast4;
    logic        valid4;
    logic        ready4;
    logic [15:0] odata4;
    logic [3:0]  ovalid4;
    logic [3:0]  oready4;
    logic [7:0]  drop4;

    logic [3:0]  data3;
    logic [1:0]  sel3;
    logic        bcast3;
    logic        valid3;
    logic        ready3;
    logic [11:0] odata3;
    logic [2:0]  ovalid3;
    logic [2:0]  oready3;
    logic [7:0]  drop3;

    int n_tests = 0;
    int n_fail  = 0;
    sb_t sb_q[$];

    always #5 clk = ~clk;

    demux_stream_1xn #(
        .BITS    (4),
        .CHANNELS(4)
    ) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (data4),
        .in_sel   (sel4),
        .in_bcast (bcast4),
        .in_valid (valid4),
        .in_ready (ready4),
        .out_data (odata4),
        .out_valid(ovalid4),
        .out_ready(oready4),
        .drop_cnt (drop4)
    );

    demux_stream_1xn #(
        .BITS    (4),
        .CHANNELS(3)
    ) dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (data3),
        .in_sel   (sel3),
        .in_bcast (bcast3),
        .in_valid (valid3),
        .in_ready (ready3),
        .out_data (odata3),
        .out_valid(ovalid3),
        .out_ready(oready3),
        .drop_cnt (drop3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input logic [3:0] d);
        sb_t e;
        e.ch   = 2'(ch);
        e.data = d;
        sb_q.push_back(e);
    endtask

    // A word leaving channel k must match the oldest expected entry for k.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (ovalid4[k] && oready4[k]) begin
                    int idx;
                    idx = -1;
                    for (int j = 0; j < sb_q.size(); j++) begin
                        if (idx < 0 && sb_q[j].ch == 2'(k)) idx = j;
                    end
                    if (idx < 0) begin
                        n_tests++;
                        n_fail++;
                        $error("FAIL sb_unexpected: observed word %0h on ch %0d expected none",
                               odata4[k*4 +: 4], k);
                    end else begin
                        chk($sformatf("sb_ch%0d", k), 32'(odata4[k*4 +: 4]),
                            32'(sb_q[idx].data));
                        sb_q.delete(idx);
                    end
                end
            end
        end
    end

    initial begin
        int not_ready;
        int stray_valid;

        rst_n   = 1'b0;
        data4   = '0; sel4 = '0; bcast4 = 1'b0; valid4 = 1'b0; oready4 = 4'hf;
        data3   = '0; sel3 = '0; bcast3 = 1'b0; valid3 = 1'b0; oready3 = 3'h7;
        #2;
        chk("rst_out_valid", 32'(ovalid4), 32'h0);
        chk("rst_out_data", 32'(odata4), 32'h0);
        chk("rst_drop_cnt", 32'(drop4), 32'h0);
        chk("rst_in_ready", 32'(ready4), 32'h1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Unicast to channel 2
        data4 = 4'ha; sel4 = 2'd2; valid4 = 1'b1;
        #1 chk("uni_in_ready", 32'(ready4), 32'h1);
        push(2, 4'ha);
        tick();
        valid4 = 1'b0;
        chk("uni_out_valid", 32'(ovalid4), 32'h4);
        chk("uni_out_data", 32'(odata4), 32'h0a00);
        tick();

        // Back-pressure on channel 1
        oready4 = 4'b1101;
        data4 = 4'h3; sel4 = 2'd1; valid4 = 1'b1;
        push(1, 4'h3);
        tick();
        data4 = 4'h5;
        #1 chk("bp_in_ready_low", 32'(ready4), 32'h0);
        chk("bp_held_data", 32'(odata4[7:4]), 32'h3);
        sel4 = 2'd0;
        #1 chk("bp_other_chan_ready", 32'(ready4), 32'h1);
        valid4 = 1'b0;
        tick();
        sel4 = 2'd1; valid4 = 1'b1;
        tick();
        chk("bp_still_valid", 32'(ovalid4[1]), 32'h1);
        chk("bp_still_data", 32'(odata4[7:4]), 32'h3);
        oready4 = 4'hf;
        #1 chk("bp_ready_after_raise", 32'(ready4), 32'h1);
        push(1, 4'h5);
        tick();
        valid4 = 1'b0;
        chk("bp_reload_valid", 32'(ovalid4[1]), 32'h1);
        chk("bp_reload_data", 32'(odata4[7:4]), 32'h5);

        // Broadcast blocked by a full channel 2
        oready4 = 4'b1011;
        data4 = 4'h9; sel4 = 2'd2; valid4 = 1'b1;
        push(2, 4'h9);
        tick();
        bcast4 = 1'b1; data4 = 4'h7;
        #1 chk("bc_in_ready_low", 32'(ready4), 32'h0);
        tick();
        chk("bc_blocked_valid", 32'(ovalid4), 32'h4);
        oready4 = 4'hf;
        #1 chk("bc_in_ready_high", 32'(ready4), 32'h1);
        for (int k = 0; k < 4; k++) push(k, 4'h7);
        tick();
        valid4 = 1'b0; bcast4 = 1'b0;
        chk("bc_out_valid", 32'(ovalid4), 32'hf);
        chk("bc_out_data", 32'(odata4), 32'h7777);

        // Back-to-back streaming across all channels
        for (int i = 0; i < 16; i++) begin
            sel4 = 2'(i % 4); data4 = 4'(i); valid4 = 1'b1;
            #1 chk($sformatf("st_ready_%0d", i), 32'(ready4), 32'h1);
            push(i % 4, 4'(i));
            tick();
            chk($sformatf("st_valid_%0d", i), 32'(ovalid4[i % 4]), 32'h1);
            chk($sformatf("st_data_%0d", i), 32'(odata4[(i % 4) * 4 +: 4]), 32'(i));
        end
        valid4 = 1'b0;
        tick();
        chk("st_drained", 32'(ovalid4), 32'h0);

        // Out-of-range select on the 3-channel instance
        not_ready   = 0;
        stray_valid = 0;
        sel3 = 2'd3; valid3 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (i == 10) chk("oor_drop_10", 32'(drop3), 32'd10);
            if (i == 255) chk("oor_drop_255", 32'(drop3), 32'd255);
            data3 = 4'(i);
            #1;
            if (!ready3) not_ready++;
            if (ovalid3 != 3'b000) stray_valid++;
            tick();
        end
        valid3 = 1'b0;
        chk("oor_not_ready_cycles", 32'(not_ready), 32'd0);
        chk("oor_stray_valid_cycles", 32'(stray_valid), 32'd0);
        chk("oor_drop_sat", 32'(drop3), 32'd255);
        chk("oor_out_valid", 32'(ovalid3), 32'h0);

        // Mid-stream asynchronous reset
        oready4 = 4'h0;
        bcast4 = 1'b1; data4 = 4'hc; valid4 = 1'b1;
        #1 chk("mr_fill_ready", 32'(ready4), 32'h1);
        for (int k = 0; k < 4; k++) push(k, 4'hc);
        tick();
        valid4 = 1'b0; bcast4 = 1'b0;
        chk("mr_full", 32'(ovalid4), 32'hf);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_out_valid", 32'(ovalid4), 32'h0);
        chk("mr_out_data", 32'(odata4), 32'h0);
        chk("mr_drop_cnt", 32'(drop3), 32'h0);
        sb_q.delete();
        #1 rst_n = 1'b1;
        oready4 = 4'hf;
        data4 = 4'h6; sel4 = 2'd0; valid4 = 1'b1;
        #1 chk("mr_resume_ready", 32'(ready4), 32'h1);
        push(0, 4'h6);
        tick();
        valid4 = 1'b0;
        chk("mr_resume_valid", 32'(ovalid4), 32'h1);
        chk("mr_resume_data", 32'(odata4[3:0]), 32'h6);
        tick();
        tick();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
